// File: rtl/bitwise_logic_pkg.sv
// Shared operation codes and FIFO entry sizing for the bitwise logic pipe.
package bitwise_logic_pkg;

  localparam logic [1:0] OP_AND     = 2'b00;
  localparam logic [1:0] OP_OR      = 2'b01;
  localparam logic [1:0] OP_XOR     = 2'b10;
  localparam logic [1:0] OP_MSBPASS = 2'b11;

  // Each queued entry carries the result plus its parity and zero flags.
  function automatic int entry_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/logic_result_fifo.sv
// In-order result queue: data written at a push edge becomes the head on the next cycle.
// Pushes while full and pops while empty are ignored. Storage is cleared on reset, so the head reads 0 when empty.
module logic_result_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [AW:0]  count_o,
  output logic         empty_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok    = push_i && (count_q != FULL_CNT);
  assign pop_ok     = pop_i && (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Bitwise op on operand pairs, optional accumulator fold, results queued in a FIFO with zero/parity flags.
// A result reaches the head 1 cycle after its accept. in_ready drops while the queue is full; the output holds under out_ready=0.
module bitwise_logic_pipe
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] txn_count
);

  localparam int          EW       = entry_w(WIDTH);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] opb, res;
  logic [EW-1:0]    push_dat, head_dat;
  logic [AW:0]      fifo_cnt;
  logic             fifo_empty;
  logic             accept;

  assign in_ready  = (fifo_cnt != FULL_CNT);
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;

  assign opb = acc_en ? (acc_clr ? '0 : acc_q) : in_b;

  always_comb begin
    res = '0;
    case (in_op)
      OP_AND: res = in_a & opb;
      OP_OR:  res = in_a | opb;
      OP_XOR: res = in_a ^ opb;
      OP_MSBPASS: begin
        res            = in_a & opb;
        res[WIDTH-1]   = in_a[WIDTH-1];
      end
      default: res = '0;
    endcase
  end

  assign push_dat = {^res, (res == '0), res};

  logic_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (accept),
    .push_dat_i (push_dat),
    .pop_i      (out_ready),
    .head_dat_o (head_dat),
    .count_o    (fifo_cnt),
    .empty_o    (fifo_empty)
  );

  assign out_result = head_dat[WIDTH-1:0];
  assign out_zero   = head_dat[WIDTH];
  assign out_parity = head_dat[WIDTH+1];

  // An accumulating accept wins over a concurrent clear; the clear already zeroed operand B.
  always_comb begin
    acc_d = acc_q;
    if (accept && acc_en) acc_d = res;
    else if (acc_clr)     acc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (accept) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_value = acc_q;
  assign txn_count = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed and random checks of bitwise_logic_pipe against a queue-based reference model.
module tb_bitwise_logic_pipe;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [1:0]    in_op;
  logic          acc_en, acc_clr;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero, out_parity;
  logic [W-1:0]  acc_value;
  logic [CW-1:0] txn_count;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_parity (out_parity),
    .acc_value  (acc_value),
    .txn_count  (txn_count)
  );

  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] macc = '0;
  int           mcnt = 0;
  bit           last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return (a & b & 8'h7F) | (a & 8'h80);
    endcase
  endfunction

  // Check everything mid-cycle, then advance the model across one rising edge.
  task automatic step();
    logic [W-1:0] b, r;
    bit           rdy, acc;
    #3;
    rdy = (mq.size() != D);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("out_result", out_result, mq[0]);
      chk("out_zero", out_zero, mq[0] == 0);
      chk("out_parity", out_parity, $countones(mq[0]) % 2);
    end
    chk("acc_value", acc_value, macc);
    chk("txn_count", txn_count, mcnt);
    b   = acc_en ? (acc_clr ? 8'h00 : macc) : in_b;
    r   = ref_op(in_a, b, in_op);
    acc = in_valid && rdy;
    @(posedge clk);
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(r);
      mcnt = (mcnt + 1) % (1 << CW);
    end
    if (acc && acc_en) macc = r;
    else if (acc_clr)  macc = '0;
    last_acc = acc;
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    step();
  endtask

  // Asynchronous reset pulse asserted mid-cycle; checks take effect before any edge.
  task automatic do_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_acc", acc_value, 0);
    chk("rst_cnt", txn_count, 0);
    mq.delete();
    macc = '0;
    mcnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    #2;
    chk("init_in_ready", in_ready, 1);
    chk("init_out_valid", out_valid, 0);
    chk("init_result", out_result, 0);
    chk("init_zero", out_zero, 0);
    chk("init_parity", out_parity, 0);
    chk("init_acc", acc_value, 0);
    chk("init_cnt", txn_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // All four operations back-to-back.
    out_ready = 1'b1;
    send(8'hCA, 8'h5F, 2'd0); chk("op_and", out_result, 8'h4A); chk("op_and_par", out_parity, 1);
    send(8'hCA, 8'h5F, 2'd1); chk("op_or", out_result, 8'hDF);  chk("op_or_par", out_parity, 1);
    send(8'hCA, 8'h5F, 2'd2); chk("op_xor", out_result, 8'h95); chk("op_xor_par", out_parity, 0);
    send(8'hCA, 8'h5F, 2'd3); chk("op_msb", out_result, 8'hCA); chk("op_msb_par", out_parity, 0);
    send(8'hF0, 8'h0F, 2'd0);
    chk("zero_res", out_result, 8'h00); chk("zero_flag", out_zero, 1); chk("zero_par", out_parity, 0);
    in_valid = 1'b0; step();

    // Accumulate with OR, then clear-and-accumulate in one accept.
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    chk("acc_cleared", acc_value, 0);
    acc_en = 1'b1;
    send(8'h01, 8'hFF, 2'd1); chk("acc_r1", out_result, 8'h01);
    send(8'h02, 8'hFF, 2'd1); chk("acc_r2", out_result, 8'h03);
    send(8'h80, 8'hFF, 2'd1); chk("acc_r3", out_result, 8'h83); chk("acc_83", acc_value, 8'h83);
    acc_clr = 1'b1;
    send(8'h0F, 8'hAA, 2'd2); chk("acc_clr_res", out_result, 8'h0F); chk("acc_0f", acc_value, 8'h0F);
    acc_clr = 1'b0; acc_en = 1'b0; in_valid = 1'b0; step();

    // Reset with three entries queued.
    out_ready = 1'b0;
    send(8'h11, 8'hFF, 2'd0); send(8'h22, 8'hFF, 2'd0); send(8'h33, 8'hFF, 2'd0);
    do_reset();
    step();
    chk("no_stale", out_valid, 0);

    // Fill to full, hold a fifth, then drain.
    for (int i = 1; i <= 4; i++) send(i[7:0], 8'h00, 2'd1);
    chk("full_rdy", in_ready, 0);
    for (int k = 0; k < 3; k++) send(8'h05, 8'h00, 2'd1);
    chk("held_cnt", txn_count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 8 && !last_acc; k++) step();
    chk("fifth_accepted", last_acc, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 8 && mq.size() > 0; k++) step();
    chk("drained", mq.size(), 0);
    chk("full_cnt5", txn_count, 5);

    // Simultaneous push and pop at two entries.
    out_ready = 1'b0;
    send(8'hA1, 8'hFF, 2'd0); send(8'hB2, 8'hFF, 2'd0);
    out_ready = 1'b1;
    send(8'hC3, 8'hFF, 2'd0);
    chk("pp_size", mq.size(), 2);
    chk("pp_head", out_result, 8'hB2);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // Counter wrap after 16 accepts from reset.
    do_reset();
    for (int k = 0; k < 16; k++) send(8'($urandom), 8'($urandom), 2'($urandom));
    in_valid = 1'b0;
    step();
    chk("cnt_wrap", txn_count, 0);

    // Random traffic; operands only change once the pending pair is taken.
    for (int k = 0; k < 300; k++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_op    = 2'($urandom);
        acc_en   = ($urandom_range(0, 2) == 0);
      end
      acc_clr   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
